// File: rtl/basic_ram_if.sv
// Request/response bundle for basic_ram: word address, write data, chip select and op enables in,
// read data and a one-cycle completion strobe out.
interface basic_ram_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_input;
  logic [DATA_WIDTH-1:0] data_output;
  logic                  cs;
  logic                  we;
  logic                  oe;
  logic                  mem_done;

  modport master (
    output address, data_input, cs, we, oe,
    input  data_output, mem_done
  );

  modport slave (
    input  address, data_input, cs, we, oe,
    output data_output, mem_done
  );
endinterface

// File: rtl/basic_ram.sv
// Single-port word RAM: mem_done pulses LATENCY cycles after a request is accepted in IDLE.
// Requests are only sampled in IDLE, so a held request is re-accepted every LATENCY+1 cycles.
module basic_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  basic_ram_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_output_q, data_output_d;
  logic                  op_we_q, op_we_d;
  logic                  mem_done_q, mem_done_d;
  logic                  req;
  logic                  mem_wr;

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  assign req = bus.cs && (bus.we || bus.oe);

  // BUSY covers LATENCY-1 cycles; DONE is the final cycle whose closing edge performs the op.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = (LATENCY == 1) ? DONE : BUSY;
      BUSY:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    op_we_d       = op_we_q;
    data_output_d = data_output_q;
    mem_done_d    = 1'b0;
    if (state_q == IDLE && req) begin
      cnt_d   = '0;
      idx_d   = bus.address[DEPTH_LOG2-1:0];
      wdata_d = bus.data_input;
      op_we_d = bus.we;
    end
    if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == DONE) begin
      mem_done_d = 1'b1;
      if (!op_we_q) begin
        data_output_d = mem[idx_q];
      end
    end
  end

  always_comb begin
    mem_wr = (state_q == DONE) && op_we_q && !rst;
  end

  assign bus.mem_done    = mem_done_q;
  assign bus.data_output = data_output_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      op_we_q       <= 1'b0;
      data_output_q <= '0;
      mem_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      op_we_q       <= op_we_d;
      data_output_q <= data_output_d;
      mem_done_q    <= mem_done_d;
    end
  end

  // Array contents survive reset; only an aborted access is suppressed.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Upper address bits alias onto the same words.
  if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.address[ADDR_WIDTH-1:DEPTH_LOG2];
  end
endmodule

// File: tb/tb_basic_ram.sv
// Directed bench for basic_ram: vector table of single accesses, then reset-abort and streaming sequences.
module tb_basic_ram;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  basic_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  basic_ram #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH_LOG2(12),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        we;
    logic        oe;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_done;
    logic [31:0] exp_dout;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one request for a single edge (or holds it for the whole window when hold=1)
  // and returns the number of edges after acceptance until mem_done, or -1 if none.
  task automatic access(input logic c, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit hold, output int lat);
    bus.cs = c; bus.we = w; bus.oe = r; bus.address = a; bus.data_input = d;
    step();
    if (!hold) begin
      bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b0;
      bus.address = 32'hFFFF_FFFF; bus.data_input = 32'h0BAD_F00D;
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.mem_done) begin
        lat = i;
        break;
      end
    end
    bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b0;
    if (lat >= 0) begin
      step();
      chk("done_width", 32'(bus.mem_done), 32'd0);
    end
  endtask

  vec_t vecs [13];
  int   lat;
  int   pulses;
  int   last_pulse;
  logic [31:0] sdat;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'hE3A0_1005, 1'b1, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hE3A0_1005};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0007, 32'hDEAD_BEEF, 1'b1, 32'hE3A0_1005};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0007, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0000_1003, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0000, 1'b1, 32'h1234_5678};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'hE3A0_1005};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0000_0007, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h0000_0007, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};

    bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b0;
    bus.address = '0; bus.data_input = '0;
    rst = 1'b1;
    repeat (3) step();
    chk("reset_done", 32'(bus.mem_done), 32'd0);
    chk("reset_dout", bus.data_output, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      access(vecs[i].cs, vecs[i].we, vecs[i].oe, vecs[i].addr, vecs[i].data,
             !vecs[i].exp_done, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), vecs[i].exp_done ? 32'(LAT) : 32'hFFFF_FFFF);
      chk($sformatf("v%0d_dout", i), bus.data_output, vecs[i].exp_dout);
    end

    // Reset two cycles in the middle of a read of word 3.
    bus.cs = 1'b1; bus.we = 1'b0; bus.oe = 1'b1; bus.address = 32'd3;
    step();
    bus.cs = 1'b0; bus.oe = 1'b0;
    pulses = 0;
    step(); if (bus.mem_done) pulses++;
    rst = 1'b1;
    step(); if (bus.mem_done) pulses++;
    step(); if (bus.mem_done) pulses++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); if (bus.mem_done) pulses++;
    end
    chk("rst_read_nopulse", 32'(pulses), 32'd0);
    chk("rst_read_dout", bus.data_output, 32'd0);
    access(1'b1, 1'b0, 1'b1, 32'd3, 32'd0, 1'b0, lat);
    chk("post_rst_lat", 32'(lat), 32'(LAT));
    chk("post_rst_dout", bus.data_output, 32'h1234_5678);

    // Reset in the middle of a write must drop the write.
    bus.cs = 1'b1; bus.we = 1'b1; bus.oe = 1'b0; bus.address = 32'd9; bus.data_input = 32'h0000_0055;
    step();
    bus.cs = 1'b0; bus.we = 1'b0;
    pulses = 0;
    step(); if (bus.mem_done) pulses++;
    rst = 1'b1;
    step(); if (bus.mem_done) pulses++;
    step(); if (bus.mem_done) pulses++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); if (bus.mem_done) pulses++;
    end
    chk("rst_write_nopulse", 32'(pulses), 32'd0);
    access(1'b1, 1'b0, 1'b1, 32'd9, 32'd0, 1'b0, lat);
    chk("rst_write_lat", 32'(lat), 32'(LAT));
    chk("rst_write_dout", bus.data_output, 32'd0);

    // Streaming writes with the request held: completions every LAT+1 cycles.
    pulses = 0;
    last_pulse = -1;
    bus.cs = 1'b1; bus.we = 1'b1; bus.oe = 1'b0;
    for (int a = 0; a < 16; a++) begin
      bus.address = 32'(a);
      bus.data_input = 32'hA5A5_0000 + 32'(a) * 32'h0000_1111;
      for (int c = 0; c < 10; c++) begin
        step();
        if (bus.mem_done) begin
          if (last_pulse >= 0) begin
            chk("stream_gap", 32'(cyc - last_pulse), 32'(LAT + 1));
          end
          last_pulse = cyc;
          pulses++;
        end
      end
    end
    bus.cs = 1'b0; bus.we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.mem_done) begin
        chk("stream_gap", 32'(cyc - last_pulse), 32'(LAT + 1));
        last_pulse = cyc;
        pulses++;
      end
    end
    chk("stream_count_ok", 32'(pulses >= 40), 32'd1);

    for (int a = 0; a < 16; a++) begin
      sdat = 32'hA5A5_0000 + 32'(a) * 32'h0000_1111;
      access(1'b1, 1'b0, 1'b1, 32'(a), 32'd0, 1'b0, lat);
      chk($sformatf("stream_rd%0d_lat", a), 32'(lat), 32'(LAT));
      chk($sformatf("stream_rd%0d_dout", a), bus.data_output, sdat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
